serial_tx_sched: RTL and testbench
==================================

// Module: serial_tx_sched
// PURPOSE
//  Arbitrates up to N_REQ requesters for one shared serial_tx instance, then sequences each transfer.
//  Latches the winner's config and drives the serial_tx control ports (tx_rst, tx_data, tx_nbits, tx_n0,
//  tx_n1, tx_cnt). Generates the timebase counter tx_cnt, detects end of frame and returns done/err/aborted.
//  Sits between requesting sequencers and the serial_tx datapath. y0 is wired directly to serial_tx.
// PARAMETERS
//  N_REQ  2  number of requesters, legal 1..8; round-robin pointer width is clog2(N_REQ), min 1
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  req        in   N_REQ      per-requester transfer request, level; held until ack
//  req_data   in   256*N_REQ  slice i=[256*i+255:256*i]; data, msb-of-frame = bit nbits-1
//  req_nbits  in   8*N_REQ    bits per frame; 0 treated as 1
//  req_n0     in   32*N_REQ   lead-in cycles; 0 treated as 1
//  req_n1     in   32*N_REQ   cycles per bit; 0 treated as 1
//  abort      in   1          terminate current transfer (effective in LOAD/RUN only)
//  ack        out  N_REQ      1-cycle pulse: request i granted, config sampled
//  done       out  N_REQ      1-cycle pulse: frame for i completed
//  err        out  N_REQ      1-cycle pulse: request i rejected (end count overflow)
//  aborted    out  1          1-cycle pulse: transfer terminated by abort
//  busy       out  1          fsm != IDLE
//  tx_rst     out  1          to serial_tx rst; high whenever no frame is running
//  tx_data    out  256        latched data;   tx_nbits out 8 latched clamped nbits
//  tx_n0      out  32         latched clamped n0; tx_n1 out 32 latched clamped n1
//  tx_cnt     out  32         timebase for serial_tx cnt
// BEHAVIOUR
//  Reset: fsm=IDLE, rr pointer=0, tx_rst=1, tx_cnt=0, tx_data=0, tx_nbits=1, tx_n0=1, tx_n1=1,
//   ack/done/err/aborted=0, busy=0. Reset mid-transfer aborts silently (no done/aborted pulse).
//  All outputs registered. States: IDLE, CALC, LOAD, RUN, DONE.
//  IDLE: tx_rst=1, tx_cnt=0. If |req: grant first set req at or after pointer (wrapping).
//   At that edge: ack[g]<=1, latch slice g with 0->1 clamps, pointer<=g+1 mod N_REQ, ->CALC.
//   req/config changes after ack are ignored.
//  CALC (1 cyc): end = n0 + nbits*n1 in 40 bits. If end[39:32]!=0: err[g]<=1, ->IDLE; else ->LOAD.
//  LOAD (1 cyc): tx_rst=1, tx_cnt=0, config stable; at edge tx_rst<=0, ->RUN.
//  RUN: first cycle tx_cnt=0; tx_cnt+=1 per cycle. At edge where tx_cnt==end[31:0]: done[g]<=1, ->DONE.
//   Serial bit k (k=0 is msb) is visible on y for tx_cnt in (n0+k*n1, n0+(k+1)*n1]; y0 from end+1 on.
//  DONE (1 cyc): tx_rst<=1, tx_cnt<=0, ->IDLE. A new grant is possible on the following cycle.
//  Back-to-back transfers: min gap from done pulse to next ack is 2 cycles.
//  abort: in LOAD/RUN, at the edge: aborted<=1, tx_rst<=1, tx_cnt<=0, ->IDLE; no done.
//   abort in IDLE/CALC/DONE is ignored. abort and tx_cnt==end on the same cycle: abort wins.
//  Clamping n0>=1 guarantees serial_tx never sees a cnt match on the first RUN cycle (tx_cnt=0).
// TESTING
//  T1 N_REQ=2, req[0], data=0xA, nbits=4, n0=3, n1=2 -> end=11; y=1 @cnt4-5, 0 @6-7, 1 @8-9,
//     0 @10-11, y0 from 12; done[0] cycle after tx_cnt==11.
//  T2 req=2'b11 after reset -> ack[0] first; ack[1] 2 cycles after done[0]. Then req=2'b11 again
//     -> ack[0] (pointer wrapped to 0 after granting 1).
//  T3 nbits=0, n0=0, n1=0 -> tx_nbits=1, tx_n0=1, tx_n1=1, end=2; RUN lasts 3 cycles, one bit sent.
//  T4 n0=0xFFFFFFF0, nbits=1, n1=0x20 -> err[0] one cycle after ack[0]; tx_rst stays 1; no done.
//  T5 abort asserted when tx_cnt==5 (T1 config) -> aborted=1 next cycle, tx_rst=1, no done[0];
//     a following req[1] completes normally.
//  T6 rst pulsed mid-RUN -> all outputs at reset values next cycle; no pulses; pointer=0.

Source files
------------

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler for a shared serial_tx: grants one requester, latches its
// frame config, checks the end count for overflow and runs the tx_cnt timebase.
module serial_tx_sched #(
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [256*N_REQ-1:0]   req_data,
  input  logic [8*N_REQ-1:0]     req_nbits,
  input  logic [32*N_REQ-1:0]    req_n0,
  input  logic [32*N_REQ-1:0]    req_n1,
  input  logic                   abort,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   aborted,
  output logic                   busy,
  output logic                   tx_rst,
  output logic [255:0]           tx_data,
  output logic [7:0]             tx_nbits,
  output logic [31:0]            tx_n0,
  output logic [31:0]            tx_n1,
  output logic [31:0]            tx_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gnt;
  logic [31:0]        r_end;
  logic [N_REQ-1:0]   r_ack;
  logic [N_REQ-1:0]   r_done;
  logic [N_REQ-1:0]   r_err;
  logic               r_aborted;
  logic               r_busy;
  logic               r_tx_rst;
  logic [255:0]       r_data;
  logic [7:0]         r_nbits;
  logic [31:0]        r_n0;
  logic [31:0]        r_n1;
  logic [31:0]        r_cnt;

  logic               w_any;
  logic [PTR_W-1:0]   w_gnt;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [255:0]       w_sel_data;
  logic [7:0]         w_sel_nbits;
  logic [31:0]        w_sel_n0;
  logic [31:0]        w_sel_n1;
  logic [39:0]        w_end;

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Scan offsets from the highest down so the nearest set request at/after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[f_wrap(r_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = f_wrap(r_ptr, k);
      end
    end
  end

  assign w_ptr_next  = (int'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + PTR_W'(1);
  assign w_sel_data  = req_data[256*int'(w_gnt) +: 256];
  assign w_sel_nbits = req_nbits[8*int'(w_gnt) +: 8];
  assign w_sel_n0    = req_n0[32*int'(w_gnt) +: 32];
  assign w_sel_n1    = req_n1[32*int'(w_gnt) +: 32];

  // Computed from the latched, already clamped config during CALC.
  assign w_end = 40'(r_nbits) * 40'(r_n1) + 40'(r_n0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_end     <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_aborted <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_rst  <= 1'b1;
      r_data    <= '0;
      r_nbits   <= 8'd1;
      r_n0      <= 32'd1;
      r_n1      <= 32'd1;
      r_cnt     <= '0;
    end else begin
      r_ack     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx_rst <= 1'b1;
          r_cnt    <= '0;
          if (w_any) begin
            r_ack[w_gnt] <= 1'b1;
            r_gnt        <= w_gnt;
            r_ptr        <= w_ptr_next;
            r_data       <= w_sel_data;
            r_nbits      <= (w_sel_nbits == 8'd0) ? 8'd1 : w_sel_nbits;
            r_n0         <= (w_sel_n0 == 32'd0) ? 32'd1 : w_sel_n0;
            r_n1         <= (w_sel_n1 == 32'd0) ? 32'd1 : w_sel_n1;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_end <= w_end[31:0];
          if (|w_end[39:32]) begin
            r_err[r_gnt] <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tx_rst <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_tx_rst  <= 1'b1;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            // Keep counting into DONE so serial_tx sees end+1 and idles on y0.
            r_cnt <= r_cnt + 32'd1;
            if (r_cnt == r_end) begin
              r_done[r_gnt] <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_tx_rst <= 1'b1;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign err      = r_err;
  assign aborted  = r_aborted;
  assign busy     = r_busy;
  assign tx_rst   = r_tx_rst;
  assign tx_data  = r_data;
  assign tx_nbits = r_nbits;
  assign tx_n0    = r_n0;
  assign tx_n1    = r_n1;
  assign tx_cnt   = r_cnt;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Scoreboard bench for serial_tx_sched: stimulus queues expected pulse events with
// their cycle gaps, a monitor pops and compares whenever a pulse appears.
module tb_serial_tx_sched;

  localparam int N_REQ = 2;
  localparam int K_ACK = 0, K_DONE = 1, K_ERR = 2, K_ABORT = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req = '0;
  logic [256*N_REQ-1:0] req_data = '0;
  logic [8*N_REQ-1:0]   req_nbits = '0;
  logic [32*N_REQ-1:0]  req_n0 = '0;
  logic [32*N_REQ-1:0]  req_n1 = '0;
  logic                 abort = 1'b0;
  logic [N_REQ-1:0]     ack, done, err;
  logic                 aborted, busy, tx_rst;
  logic [255:0]         tx_data;
  logic [7:0]           tx_nbits;
  logic [31:0]          tx_n0, tx_n1, tx_cnt;

  serial_tx_sched #(.N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_nbits(req_nbits),
    .req_n0(req_n0), .req_n1(req_n1), .abort(abort), .ack(ack), .done(done),
    .err(err), .aborted(aborted), .busy(busy), .tx_rst(tx_rst), .tx_data(tx_data),
    .tx_nbits(tx_nbits), .tx_n0(tx_n0), .tx_n1(tx_n1), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int idx;
    int gap;   // cycles since previous event, -1 = unchecked
  } evt_t;

  evt_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  function automatic logic pulse_now(input int kind, input int idx);
    case (kind)
      K_ACK:   return ack[idx];
      K_DONE:  return done[idx];
      K_ERR:   return err[idx];
      default: return aborted;
    endcase
  endfunction

  task automatic handle_evt(input int kind, input int idx);
    evt_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_evt: got kind=%0d idx=%0d expected none", kind, idx);
    end else begin
      e = sb_q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_idx", idx, e.idx);
      if (e.gap >= 0) chk("evt_gap", cyc - last_cyc, e.gap);
    end
    last_cyc = cyc;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < N_REQ; i++)
          if (pulse_now(k, i)) handle_evt(k, i);
      if (aborted) handle_evt(K_ABORT, 0);
    end
  end

  task automatic push(input int kind, input int idx, input int gap);
    evt_t e;
    e.kind = kind;
    e.idx = idx;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int kind, input int idx, input string name);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (pulse_now(kind, idx)) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected pulse", name);
  endtask

  task automatic set_cfg(input int i, input logic [255:0] d, input logic [7:0] nb,
                         input logic [31:0] a0, input logic [31:0] a1);
    req_data[256*i +: 256] = d;
    req_nbits[8*i +: 8]    = nb;
    req_n0[32*i +: 32]     = a0;
    req_n1[32*i +: 32]     = a1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_rst"}, tx_rst, 1);
    chk({tag, "_tx_cnt"}, tx_cnt, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_cfg"}, {tx_nbits, tx_n0, tx_n1}, {8'd1, 32'd1, 32'd1});
    chk({tag, "_pulses"}, {ack, done, err, aborted, busy}, 0);
  endtask

  initial begin
    step(3);
    chk_reset("reset");
    rst = 1'b0;
    step(1);

    // T1: single frame, end = 3 + 4*2 = 11, done 14 cycles after ack
    set_cfg(0, 256'hA, 8'd4, 32'd3, 32'd2);
    push(K_ACK, 0, -1);
    push(K_DONE, 0, 14);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t1_ack");
    req = 2'b00;
    chk("t1_latched", {tx_data[31:0], tx_nbits, tx_n0, tx_n1}, {32'hA, 8'd4, 32'd3, 32'd2});
    chk("t1_busy_rst", {busy, tx_rst}, 2'b11);
    step(2);
    chk("t1_run_start", {tx_rst, tx_cnt}, {1'b0, 32'd0});
    step(11);
    chk("t1_cnt_end", tx_cnt, 11);
    step(1);
    chk("t1_done_cnt", {tx_rst, tx_cnt}, {1'b0, 32'd12});
    step(1);
    chk("t1_back_idle", {busy, tx_rst, tx_cnt}, {1'b0, 1'b1, 32'd0});

    // T2: round robin after reset
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    set_cfg(1, 256'hA, 8'd4, 32'd3, 32'd2);
    push(K_ACK, 0, -1);
    push(K_DONE, 0, 14);
    push(K_ACK, 1, 2);
    push(K_DONE, 1, 14);
    req = 2'b11;
    wait_pulse(K_ACK, 0, "t2_ack0");
    req[0] = 1'b0;
    wait_pulse(K_ACK, 1, "t2_ack1");
    req[1] = 1'b0;
    wait_pulse(K_DONE, 1, "t2_done1");
    step(2);
    push(K_ACK, 0, -1);
    push(K_DONE, 0, 14);
    req = 2'b11;
    wait_pulse(K_ACK, 0, "t2_ack0_again");
    req = 2'b00;
    wait_pulse(K_DONE, 0, "t2_done0_again");
    step(2);

    // T3: all-zero config clamps to 1, end = 2
    set_cfg(0, 256'h1, 8'd0, 32'd0, 32'd0);
    push(K_ACK, 0, -1);
    push(K_DONE, 0, 5);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t3_ack");
    req = 2'b00;
    chk("t3_clamped", {tx_nbits, tx_n0, tx_n1}, {8'd1, 32'd1, 32'd1});
    wait_pulse(K_DONE, 0, "t3_done");
    chk("t3_done_cnt", tx_cnt, 3);
    step(2);

    // T4: end count overflows 32 bits -> err, no frame
    set_cfg(0, 256'h1, 8'd1, 32'hFFFF_FFF0, 32'h20);
    push(K_ACK, 0, -1);
    push(K_ERR, 0, 1);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t4_ack");
    req = 2'b00;
    step(1);
    chk("t4_err_state", {busy, tx_rst, tx_cnt}, {1'b0, 1'b1, 32'd0});
    step(3);
    chk("t4_stays_rst", tx_rst, 1);

    // abort while idle must be ignored
    abort = 1'b1;
    step(3);
    abort = 1'b0;
    chk("idle_abort_ignored", busy, 0);

    // T5: abort at tx_cnt == 5, then requester 1 completes
    set_cfg(0, 256'hA, 8'd4, 32'd3, 32'd2);
    push(K_ACK, 0, -1);
    push(K_ABORT, 0, 8);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t5_ack");
    req = 2'b00;
    step(7);
    chk("t5_cnt_at_abort", tx_cnt, 5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5_after_abort", {busy, tx_rst, tx_cnt}, {1'b0, 1'b1, 32'd0});
    push(K_ACK, 1, -1);
    push(K_DONE, 1, 14);
    req = 2'b10;
    wait_pulse(K_ACK, 1, "t5_ack1");
    req = 2'b00;
    wait_pulse(K_DONE, 1, "t5_done1");
    step(2);

    // abort on the same cycle as tx_cnt == end: abort wins
    push(K_ACK, 0, -1);
    push(K_ABORT, 0, 14);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t5b_ack");
    req = 2'b00;
    step(13);
    chk("t5b_cnt_end", tx_cnt, 11);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5b_after_abort", {tx_rst, tx_cnt}, {1'b1, 32'd0});
    step(2);

    // T6: reset mid-RUN, then pointer must be back at 0
    push(K_ACK, 0, -1);
    req = 2'b01;
    wait_pulse(K_ACK, 0, "t6_ack");
    req = 2'b00;
    step(5);
    rst = 1'b1;
    step(1);
    chk_reset("t6_reset");
    rst = 1'b0;
    step(3);
    push(K_ACK, 0, -1);
    push(K_DONE, 0, 14);
    req = 2'b11;
    wait_pulse(K_ACK, 0, "t6_ack_ptr0");
    req = 2'b00;
    wait_pulse(K_DONE, 0, "t6_done");
    step(5);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
